// File: rtl/regs_wr_arbiter.sv
// Round-robin write-port arbiter for the picoMIPS register file, with locked
// bursts bounded by a fairness counter and registered w/waddr/wdata outputs.
module regs_wr_arbiter #(
   parameter int ADDR_WIDTH = 1,
   parameter int DATA_WIDTH = 8,
   parameter int MAX_BURST  = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req0_valid,
   input  logic                  req0_lock,
   input  logic [ADDR_WIDTH-1:0] req0_addr,
   input  logic [DATA_WIDTH-1:0] req0_data,
   output logic                  req0_gnt,
   input  logic                  req1_valid,
   input  logic                  req1_lock,
   input  logic [ADDR_WIDTH-1:0] req1_addr,
   input  logic [DATA_WIDTH-1:0] req1_data,
   output logic                  req1_gnt,
   output logic                  w,
   output logic [ADDR_WIDTH-1:0] waddr,
   output logic [DATA_WIDTH-1:0] wdata,
   output logic                  last_owner
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } state_t;

   localparam logic [3:0] MAX_CNT = 4'(MAX_BURST);

   state_t                  state_r;
   logic [3:0]              burst_cnt_r;
   logic                    last_owner_r;
   logic                    w_r;
   logic [ADDR_WIDTH-1:0]   waddr_r;
   logic [DATA_WIDTH-1:0]   wdata_r;

   logic                    owned_s;
   logic                    owner_s;
   logic                    owner_valid_s;
   logic                    other_valid_s;
   logic                    hold_s;
   logic                    gnt0_s;
   logic                    gnt1_s;
   logic                    accept_s;
   logic                    sel_s;
   logic                    sel_lock_s;
   logic [ADDR_WIDTH-1:0]   sel_addr_s;
   logic [DATA_WIDTH-1:0]   sel_data_s;
   state_t                  sel_own_s;

   // Grant decision: depends only on valids, state, last_owner and burst_cnt
   always_comb begin
      owned_s = 1'b0;
      owner_s = 1'b0;
      case (state_r)
         OWN0: begin
            owned_s = 1'b1;
            owner_s = 1'b0;
         end
         OWN1: begin
            owned_s = 1'b1;
            owner_s = 1'b1;
         end
         default: begin
            owned_s = 1'b0;
            owner_s = 1'b0;
         end
      endcase

      owner_valid_s = owner_s ? req1_valid : req0_valid;
      other_valid_s = owner_s ? req0_valid : req1_valid;
      // A lock holds only while the owner keeps valid up and fairness is not due
      hold_s = owned_s && owner_valid_s && !((burst_cnt_r >= MAX_CNT) && other_valid_s);

      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
      if (reset) begin
         gnt0_s = 1'b0;
         gnt1_s = 1'b0;
      end else if (hold_s) begin
         gnt0_s = ~owner_s;
         gnt1_s = owner_s;
      end else if (req0_valid && req1_valid) begin
         gnt0_s = last_owner_r;
         gnt1_s = ~last_owner_r;
      end else begin
         gnt0_s = req0_valid;
         gnt1_s = req1_valid;
      end
   end

   // Mux the granted requester's beat towards the output register
   always_comb begin
      accept_s = gnt0_s | gnt1_s;
      sel_s    = gnt1_s;
      if (gnt1_s) begin
         sel_lock_s = req1_lock;
         sel_addr_s = req1_addr;
         sel_data_s = req1_data;
         sel_own_s  = OWN1;
      end else begin
         sel_lock_s = req0_lock;
         sel_addr_s = req0_addr;
         sel_data_s = req0_data;
         sel_own_s  = OWN0;
      end
   end

   // Ownership FSM, fairness counter and registered write port
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r      <= IDLE;
         burst_cnt_r  <= 4'd0;
         last_owner_r <= 1'b1;
         w_r          <= 1'b0;
         waddr_r      <= '0;
         wdata_r      <= '0;
      end else if (accept_s) begin
         w_r          <= 1'b1;
         waddr_r      <= sel_addr_s;
         wdata_r      <= sel_data_s;
         last_owner_r <= sel_s;
         if (sel_lock_s) begin
            // burst_cnt counts beats of the current locked burst, entry beat included
            if (state_r == sel_own_s) begin
               burst_cnt_r <= (burst_cnt_r >= MAX_CNT) ? MAX_CNT : burst_cnt_r + 4'd1;
            end else begin
               burst_cnt_r <= 4'd1;
            end
            state_r <= sel_own_s;
         end else begin
            state_r     <= IDLE;
            burst_cnt_r <= 4'd0;
         end
      end else begin
         w_r         <= 1'b0;
         state_r     <= IDLE;
         burst_cnt_r <= 4'd0;
      end
   end

   assign req0_gnt   = gnt0_s;
   assign req1_gnt   = gnt1_s;
   assign w          = w_r;
   assign waddr      = waddr_r;
   assign wdata      = wdata_r;
   assign last_owner = last_owner_r;

endmodule

// File: tb/tb_regs_wr_arbiter.sv
// Scoreboard bench for regs_wr_arbiter: directed scenarios followed by random
// traffic, checked against a burst/round-robin reference model.
module tb_regs_wr_arbiter;

   localparam int AW        = 1;
   localparam int DW        = 8;
   localparam int MAX_BURST = 4;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          req0_valid = 1'b0, req0_lock = 1'b0, req0_gnt;
   logic          req1_valid = 1'b0, req1_lock = 1'b0, req1_gnt;
   logic [AW-1:0] req0_addr = '0, req1_addr = '0, waddr;
   logic [DW-1:0] req0_data = '0, req1_data = '0, wdata;
   logic          w, last_owner;

   regs_wr_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST(MAX_BURST)) dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_lock(req0_lock), .req0_addr(req0_addr),
      .req0_data(req0_data), .req0_gnt(req0_gnt),
      .req1_valid(req1_valid), .req1_lock(req1_lock), .req1_addr(req1_addr),
      .req1_data(req1_data), .req1_gnt(req1_gnt),
      .w(w), .waddr(waddr), .wdata(wdata), .last_owner(last_owner)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   logic [AW+DW-1:0] exp_q[$];

   // reference model: owner of a locked burst (-1 none), beats in that burst, last granted
   int m_lock = -1;
   int m_run  = 0;
   int m_last = 1;
   bit h0 = 1'b0, h1 = 1'b0;

   task automatic check(input string name, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   function automatic int model_pick(input bit v0, input bit v1);
      bit v[2];
      v[0] = v0;
      v[1] = v1;
      if (m_lock >= 0 && v[m_lock] && !(m_run >= MAX_BURST && v[1-m_lock])) return m_lock;
      if (v0 && v1) return 1 - m_last;
      if (v0) return 0;
      if (v1) return 1;
      return -1;
   endfunction

   // monitor: every write presented to regs must match the oldest accepted beat
   always @(negedge clk) begin
      if (!reset && w) begin
         if (exp_q.size() == 0) begin
            check("unexpected_w", 1, 0);
         end else begin
            logic [AW+DW-1:0] e;
            e = exp_q.pop_front();
            check("waddr", int'(waddr), int'(e[AW+DW-1:DW]));
            check("wdata", int'(wdata), int'(e[DW-1:0]));
         end
      end
   end

   // one bus cycle; entered and left at posedge+1; exp_g=-2 means no directed expectation
   task automatic step(input bit v0, input bit l0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                       input bit v1, input bit l1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                       input int exp_g);
      int g, gd;
      bit lk;
      req0_valid = v0; req0_lock = l0; req0_addr = a0; req0_data = d0;
      req1_valid = v1; req1_lock = l1; req1_addr = a1; req1_data = d1;
      @(negedge clk);
      #1;
      g  = model_pick(v0, v1);
      gd = req0_gnt ? 0 : (req1_gnt ? 1 : -1);
      check("gnt0", int'(req0_gnt), int'(g == 0));
      check("gnt1", int'(req1_gnt), int'(g == 1));
      check("last_owner", int'(last_owner), m_last);
      if (exp_g != -2) check("directed_grant", gd, exp_g);
      h0 = v0 && !req0_gnt;
      h1 = v1 && !req1_gnt;
      if (g >= 0) begin
         exp_q.push_back(g == 1 ? {a1, d1} : {a0, d0});
         lk = (g == 1) ? l1 : l0;
         if (lk) begin
            if (m_lock == g) m_run = (m_run >= MAX_BURST) ? MAX_BURST : m_run + 1;
            else m_run = 1;
            m_lock = g;
         end else begin
            m_lock = -1;
            m_run  = 0;
         end
         m_last = g;
      end else begin
         m_lock = -1;
         m_run  = 0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input int n);
      reset = 1'b1;
      exp_q.delete();
      m_lock = -1;
      m_run  = 0;
      m_last = 1;
      h0 = 1'b0;
      h1 = 1'b0;
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         #1;
         check("rst_gnt0", int'(req0_gnt), 0);
         check("rst_gnt1", int'(req1_gnt), 0);
         check("rst_w", int'(w), 0);
         check("rst_waddr", int'(waddr), 0);
         check("rst_wdata", int'(wdata), 0);
         check("rst_last_owner", int'(last_owner), 1);
         @(posedge clk);
         #1;
      end
      reset = 1'b0;
   endtask

   initial begin
      bit rv0, rl0, rv1, rl1;
      logic [AW-1:0] ra0, ra1;
      logic [DW-1:0] rd0, rd1;

      // reset with both requesters valid, then round-robin alternation
      req0_valid = 1'b1; req0_data = 8'h0A; req0_addr = 1'b0;
      req1_valid = 1'b1; req1_data = 8'h05; req1_addr = 1'b1;
      do_reset(3);
      step(1'b1, 1'b0, 1'b0, 8'h0A, 1'b1, 1'b0, 1'b1, 8'h05, 0);
      step(1'b1, 1'b0, 1'b0, 8'h0A, 1'b1, 1'b0, 1'b1, 8'h05, 1);
      step(1'b1, 1'b0, 1'b0, 8'h0A, 1'b1, 1'b0, 1'b1, 8'h05, 0);
      step(1'b1, 1'b0, 1'b0, 8'h0A, 1'b1, 1'b0, 1'b1, 8'h05, 1);

      // locked burst of three from req0 with req1 idle
      step(1'b1, 1'b1, 1'b0, 8'h11, 1'b0, 1'b0, 1'b0, 8'h00, 0);
      step(1'b1, 1'b1, 1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 8'h00, 0);
      step(1'b1, 1'b0, 1'b0, 8'h33, 1'b0, 1'b0, 1'b0, 8'h00, 0);
      step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, -1);

      // fairness: req0 locked continuously, req1 waiting throughout
      step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h44, 1);
      for (int k = 0; k < 10; k++) begin
         step(1'b1, 1'b1, 1'b0, 8'(8'h50 + k), 1'b1, 1'b0, 1'b1, 8'(8'hA0 + k),
              (k == 4 || k == 9) ? 1 : 0);
      end

      // lock bubble: owner drops valid for one cycle, req1 is served
      step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, -1);
      step(1'b1, 1'b1, 1'b0, 8'h61, 1'b0, 1'b0, 1'b0, 8'h00, 0);
      step(1'b0, 1'b1, 1'b0, 8'h61, 1'b1, 1'b0, 1'b1, 8'h62, 1);
      step(1'b1, 1'b0, 1'b0, 8'h63, 1'b1, 1'b0, 1'b1, 8'h64, 0);

      // mid-burst reset during an OWN1 burst
      step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h71, 1);
      step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h72, 1);
      req0_valid = 1'b1;
      do_reset(2);
      step(1'b1, 1'b0, 1'b1, 8'h81, 1'b1, 1'b1, 1'b1, 8'h82, 0);

      // random traffic honouring the hold-while-waiting rule
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 299) == 0) do_reset(1);
         if (!h0) begin
            rv0 = ($urandom_range(0, 3) != 0);
            rl0 = ($urandom_range(0, 3) != 0);
            ra0 = AW'($urandom_range(0, 1));
            rd0 = DW'($urandom_range(0, 255));
         end
         if (!h1) begin
            rv1 = ($urandom_range(0, 3) != 0);
            rl1 = ($urandom_range(0, 2) == 0);
            ra1 = AW'($urandom_range(0, 1));
            rd1 = DW'($urandom_range(0, 255));
         end
         step(rv0, rl0, ra0, rd0, rv1, rl1, ra1, rd1, -2);
      end

      // drain and confirm every accepted beat reached the write port
      for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, -1);
      check("queue_drained", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/regs_wr_arbiter.md
# regs_wr_arbiter

Arbitrates the single write port of the picoMIPS register file (`regs`: accumulator gpr[0], general register gpr[1], …) between two write requesters. Requester 0 is the core writeback stage; requester 1 is the debug/loader port. The block uses round-robin priority, with optional locked bursts bounded by a fairness counter. It drives registered `w`/`waddr`/`wdata` straight into `regs`.

## Interface
- `ADDR_WIDTH`, 1, register address width; matches `regs`.
- `DATA_WIDTH`, 8, register data width.
- `MAX_BURST`, 4, maximum consecutive locked grants to one requester while the other is waiting; legal range 1–15.

- `clk`  in  1  system clock; all state updates on posedge.
- `reset`  in  1  asynchronous, active-high reset.
- `req0_valid`  in  1  requester 0 has a write pending.
- `req0_lock`  in  1  requester 0 asks to keep the grant after this beat.
- `req0_addr`  in  ADDR_WIDTH  requester 0 target register.
- `req0_data`  in  DATA_WIDTH  requester 0 write data.
- `req0_gnt`  out  1  requester 0 write accepted this cycle (combinational).
- `req1_valid`, `req1_lock`, `req1_addr`, `req1_data`, `req1_gnt`: same as requester 0, for requester 1.
- `w`  out  1  registered write enable to `regs`.
- `waddr`  out  ADDR_WIDTH  registered write address to `regs`.
- `wdata`  out  DATA_WIDTH  registered write data to `regs`.
- `last_owner`  out  1  index of the most recently granted requester.

## Operation
- A handshake completes when `reqN_valid && reqN_gnt` at a posedge. A requester must hold `addr`, `data` and `lock` stable while `valid` is high and `gnt` is low.
- At most one `gnt` is high per cycle. A `gnt` is never high without its `valid`.
- Arbiter states:
  - IDLE: no owner. Grant goes to the valid requester. If both are valid, grant goes to the one that is not `last_owner` (round-robin).
  - OWN0 / OWN1: entered after an accepted beat with `lock=1`. The owner has exclusive grant. The other requester's `gnt` is forced low.
- Transitions out of OWNn:
  - Owner beat accepted with `lock=0` → IDLE.
  - Owner `valid` low for one cycle → IDLE (the lock is dropped and not held across bubbles).
  - `burst_cnt` reaches `MAX_BURST` while the other requester is valid → IDLE for exactly one cycle. In that cycle round-robin grants the other requester, even if the owner is also valid.
- `burst_cnt` (4 bit):
  - Cleared on entry to IDLE and on a change of owner.
  - Incremented on each accepted beat in OWNn.
  - Saturates at `MAX_BURST`.
- `last_owner` updates to the index of every accepted beat. It resets to 1, so requester 0 wins the first tie.
- Output register behaviour:
  - On an accepted beat: `w` ← 1, `waddr` ← granted addr, `wdata` ← granted data.
  - Otherwise: `w` ← 0; `waddr` and `wdata` hold their previous values.
- Back-to-back writes to the same address are passed through in acceptance order. No merging, no reordering.

## Timing
- Reset values: `w`=0, `waddr`=0, `wdata`=0, `last_owner`=1, state=IDLE, `burst_cnt`=0. `req0_gnt` and `req1_gnt` are 0 while `reset` is high.
- `gnt` is combinational from `valid`, state, `last_owner` and `burst_cnt`. There is no combinational path from `lock` or `data` to `gnt`.
- Latency:
  - Beat accepted at edge N → `w`=1 during cycle N→N+1.
  - `regs` captures the write at edge N+1.
  - The value is readable on `data*_q` after edge N+1.
- Throughput: one write per cycle sustained, including across owner changes.
- If `reset` is asserted mid-burst, state returns to IDLE immediately and any in-flight `w` is dropped. A beat whose posedge coincides with `reset` is not accepted.
- If both requesters go valid in the same cycle the OWNn lock is released, the non-`last_owner` requester wins.

## Test plan
- Reset: hold `reset`=1 with both valid → both `gnt`=0 and `w`=0. Release reset with both valid → `req0_gnt`=1. One cycle later: `w`=1, `waddr`=0, `wdata`=req0_data.
- Round-robin: both valid every cycle with `lock`=0, req0 writing 8'h0A to addr 0 and req1 writing 8'h05 to addr 1 → grants alternate 0,1,0,1. Final `regs` state: gpr[0]=0A, gpr[1]=05.
- Lock burst: req0 sends 3 beats with `lock`=1 (the last beat with `lock`=0) while req1 stays idle → 3 consecutive `req0_gnt`, `w` high for 3 cycles, state returns to IDLE.
- Fairness: `MAX_BURST`=4, req0 holds `lock`=1 continuously, req1 valid throughout → req0 gets 4 grants, then req1 gets exactly 1 grant, then req0 resumes.
- Lock bubble: req0 is in OWN0 and drops `valid` for one cycle while req1 is valid → req1 is granted in that cycle.
- Mid-burst reset: assert `reset` during an OWN1 burst → `w` is 0 on the next sample, both `gnt` are 0, and after release a tie grants req0.
